// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data memory access unit.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/halfword lane of a read word and zero- or
// sign-extends it to 32 bits; words pass through unchanged.
module load_formatter
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        is_signed,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (lane)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

      // Size 2'b11 is treated as a word access.
      case (size)
         SZ_BYTE: data = {{24{is_signed & byte_sel[7]}}, byte_sel};
         SZ_HALF: data = {{16{is_signed & half_sel[15]}}, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: turns load/store requests into a
// req/ack bus transaction, formats load data and stalls the pipeline meanwhile.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemSize,
   input  logic        MemSigned,
   input  logic [31:0] ALUOut,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AddrErr,
   output logic        BusErr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   localparam bit         TO_EN   = (TIMEOUT != 0);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic        access;
   logic        misaligned;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] fmt_data;
   logic        timeout_hit;

   assign access      = MemRead | MemWrite;
   assign misaligned  = ((MemSize == SZ_HALF) && ALUOut[0]) ||
                        (MemSize[1] && (ALUOut[1:0] != 2'b00));
   assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

   // Stall and AddrErr must react in the same cycle the request shows up.
   assign Stall   = !RST && ((state == ST_BUSY) ||
                             ((state == ST_IDLE) && access && !misaligned));
   assign AddrErr = !RST && (state == ST_IDLE) && access && misaligned;

   always_comb begin
      case (MemSize)
         SZ_BYTE: begin
            be_next    = 4'b0001 << ALUOut[1:0];
            wdata_next = {4{WriteData[7:0]}};
         end
         SZ_HALF: begin
            be_next    = 4'b0011 << ALUOut[1:0];
            wdata_next = {2{WriteData[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = WriteData;
         end
      endcase
   end

   load_formatter u_fmt (
      .rdata     (mem_rdata),
      .lane      (lane_q),
      .size      (size_q),
      .is_signed (signed_q),
      .data      (fmt_data)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         ReadData  <= 32'd0;
         BusErr    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 30'd0;
         mem_be    <= 4'd0;
         mem_wdata <= 32'd0;
         wait_cnt  <= 8'd0;
         lane_q    <= 2'd0;
         size_q    <= 2'd0;
         signed_q  <= 1'b0;
      end else begin
         BusErr <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (access && !misaligned) begin
                  mem_req   <= 1'b1;
                  mem_we    <= MemWrite;
                  mem_addr  <= ALUOut[31:2];
                  mem_be    <= be_next;
                  mem_wdata <= wdata_next;
                  lane_q    <= ALUOut[1:0];
                  size_q    <= MemSize;
                  signed_q  <= MemSigned;
                  wait_cnt  <= 8'd0;
                  state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (!mem_we)
                     ReadData <= fmt_data;
                  state <= ST_DONE;
               end else if (timeout_hit) begin
                  mem_req  <= 1'b0;
                  BusErr   <= 1'b1;
                  ReadData <= 32'd0;
                  state    <= ST_DONE;
               end else if (wait_cnt != 8'hFF) begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; a second instance with TIMEOUT=4
// exercises the bus-timeout path.
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        MemRead, MemWrite, MemSigned;
   logic [1:0]  MemSize;
   logic [31:0] ALUOut, WriteData;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic [31:0] ReadData, mem_wdata;
   logic        Stall, AddrErr, BusErr, mem_req, mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;

   logic [31:0] to_ReadData, to_mem_wdata;
   logic        to_Stall, to_AddrErr, to_BusErr, to_mem_req, to_mem_we;
   logic [29:0] to_mem_addr;
   logic [3:0]  to_mem_be;

   int checks = 0;
   int errors = 0;

   int          obs_stall;
   logic [29:0] obs_addr;
   logic [3:0]  obs_be;
   logic [31:0] obs_wdata;
   logic        obs_we;
   bit          obs_stable;
   logic [31:0] obs_rdata;
   logic        obs_req_done;

   mem_access_unit dut (
      .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemSize(MemSize), .MemSigned(MemSigned), .ALUOut(ALUOut),
      .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
      .AddrErr(AddrErr), .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   mem_access_unit #(.TIMEOUT(4)) dut_to (
      .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemSize(MemSize), .MemSigned(MemSigned), .ALUOut(ALUOut),
      .WriteData(WriteData), .ReadData(to_ReadData), .Stall(to_Stall),
      .AddrErr(to_AddrErr), .BusErr(to_BusErr), .mem_req(to_mem_req),
      .mem_we(to_mem_we), .mem_addr(to_mem_addr), .mem_be(to_mem_be),
      .mem_wdata(to_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic set_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic sg, input logic [31:0] addr,
                             input logic [31:0] wd);
      MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
      ALUOut = addr; WriteData = wd;
   endtask

   // Drives one transaction to completion, acking after 'waits' BUSY cycles,
   // and records what the bus and pipeline interface looked like.
   task automatic run_access(input int waits, input logic [31:0] rdata);
      int busy = 0;
      bit first = 1;
      obs_stall = 0;
      obs_stable = 1;
      for (int c = 0; c < 300; c++) begin
         #1;
         if (!Stall) break;
         obs_stall++;
         if (mem_req) begin
            if (first) begin
               obs_addr = mem_addr; obs_be = mem_be;
               obs_wdata = mem_wdata; obs_we = mem_we;
               first = 0;
            end else if (mem_addr !== obs_addr || mem_be !== obs_be ||
                         mem_wdata !== obs_wdata || mem_we !== obs_we) begin
               obs_stable = 0;
            end
            if (busy == waits) begin
               mem_ack = 1'b1;
               mem_rdata = rdata;
            end
            busy++;
         end
         step();
         mem_ack = 1'b0;
      end
      obs_rdata = ReadData;
      obs_req_done = mem_req;
      MemRead = 1'b0;
      MemWrite = 1'b0;
      step();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      set_access(0, 0, 2'b00, 0, 32'h0, 32'h0);
      mem_ack = 1'b0; mem_rdata = 32'h0;
      step(); step();
      #1;
      checks++; if ({ReadData, mem_wdata} !== 64'd0) begin errors++; $display("[TB] FAIL reset_data got %h/%h want 0", ReadData, mem_wdata); end
      checks++; if ({Stall, AddrErr, BusErr} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {Stall, AddrErr, BusErr}); end
      checks++; if ({mem_req, mem_we, mem_be} !== 6'd0) begin errors++; $display("[TB] FAIL reset_bus got %b want 0", {mem_req, mem_we, mem_be}); end
      checks++; if (mem_addr !== 30'd0) begin errors++; $display("[TB] FAIL reset_addr got %h want 0", mem_addr); end
      RST = 1'b0;
      step();
   endtask

   task automatic test_word_load();
      set_access(1, 0, 2'b10, 0, 32'h100, 32'h0);
      run_access(0, 32'hDEADBEEF);
      checks++; if (obs_stall !== 2) begin errors++; $display("[TB] FAIL word_stall got %0d want 2", obs_stall); end
      checks++; if (obs_addr !== 30'h40) begin errors++; $display("[TB] FAIL word_addr got %h want 40", obs_addr); end
      checks++; if (obs_be !== 4'b1111) begin errors++; $display("[TB] FAIL word_be got %b want 1111", obs_be); end
      checks++; if (obs_we !== 1'b0) begin errors++; $display("[TB] FAIL word_we got %b want 0", obs_we); end
      checks++; if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL word_rdata got %h want deadbeef", obs_rdata); end
      checks++; if (obs_req_done !== 1'b0) begin errors++; $display("[TB] FAIL word_req_done got %b want 0", obs_req_done); end
   endtask

   task automatic test_timeout();
      int cnt = 0;
      set_access(1, 0, 2'b10, 0, 32'h10, 32'h0);
      for (int c = 0; c < 50; c++) begin
         #1;
         if (!to_Stall) break;
         cnt++;
         step();
      end
      checks++; if (cnt !== 5) begin errors++; $display("[TB] FAIL to_stall got %0d want 5", cnt); end
      checks++; if (to_BusErr !== 1'b1) begin errors++; $display("[TB] FAIL to_buserr got %b want 1", to_BusErr); end
      checks++; if (to_ReadData !== 32'd0) begin errors++; $display("[TB] FAIL to_rdata got %h want 0", to_ReadData); end
      checks++; if (to_mem_req !== 1'b0) begin errors++; $display("[TB] FAIL to_req got %b want 0", to_mem_req); end
      MemRead = 1'b0;
      step();
      #1;
      checks++; if ({to_BusErr, to_Stall} !== 2'b00) begin errors++; $display("[TB] FAIL to_after got %b want 00", {to_BusErr, to_Stall}); end
      RST = 1'b1;
      step();
      RST = 1'b0;
      step();
   endtask

   task automatic test_byte_load();
      set_access(1, 0, 2'b00, 1, 32'h103, 32'h0);
      run_access(1, 32'h80112233);
      checks++; if (obs_stall !== 3) begin errors++; $display("[TB] FAIL sbyte_stall got %0d want 3", obs_stall); end
      checks++; if (obs_be !== 4'b1000) begin errors++; $display("[TB] FAIL sbyte_be got %b want 1000", obs_be); end
      checks++; if (obs_rdata !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL sbyte_rdata got %h want ffffff80", obs_rdata); end
      set_access(1, 0, 2'b00, 0, 32'h103, 32'h0);
      run_access(0, 32'h80112233);
      checks++; if (obs_rdata !== 32'h00000080) begin errors++; $display("[TB] FAIL ubyte_rdata got %h want 00000080", obs_rdata); end
      checks++; if (obs_addr !== 30'h40) begin errors++; $display("[TB] FAIL ubyte_addr got %h want 40", obs_addr); end
   endtask

   task automatic test_half();
      set_access(1, 0, 2'b01, 1, 32'h206, 32'h0);
      run_access(0, 32'h80011234);
      checks++; if (obs_be !== 4'b1100) begin errors++; $display("[TB] FAIL shalf_be got %b want 1100", obs_be); end
      checks++; if (obs_rdata !== 32'hFFFF8001) begin errors++; $display("[TB] FAIL shalf_rdata got %h want ffff8001", obs_rdata); end
      set_access(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD);
      run_access(4, 32'h0);
      checks++; if (obs_stall !== 6) begin errors++; $display("[TB] FAIL hstore_stall got %0d want 6", obs_stall); end
      checks++; if (obs_be !== 4'b1100) begin errors++; $display("[TB] FAIL hstore_be got %b want 1100", obs_be); end
      checks++; if (obs_wdata !== 32'hABCDABCD) begin errors++; $display("[TB] FAIL hstore_wdata got %h want abcdabcd", obs_wdata); end
      checks++; if (obs_we !== 1'b1) begin errors++; $display("[TB] FAIL hstore_we got %b want 1", obs_we); end
      checks++; if (obs_addr !== 30'h80) begin errors++; $display("[TB] FAIL hstore_addr got %h want 80", obs_addr); end
      checks++; if (obs_stable !== 1'b1) begin errors++; $display("[TB] FAIL hstore_stable got %b want 1", obs_stable); end
      checks++; if (obs_rdata !== 32'hFFFF8001) begin errors++; $display("[TB] FAIL hstore_rdata got %h want ffff8001", obs_rdata); end
   endtask

   task automatic test_write_priority();
      set_access(1, 1, 2'b00, 0, 32'h301, 32'h1234565A);
      run_access(0, 32'h99999999);
      checks++; if (obs_we !== 1'b1) begin errors++; $display("[TB] FAIL bstore_we got %b want 1", obs_we); end
      checks++; if (obs_be !== 4'b0010) begin errors++; $display("[TB] FAIL bstore_be got %b want 0010", obs_be); end
      checks++; if (obs_wdata !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL bstore_wdata got %h want 5a5a5a5a", obs_wdata); end
      set_access(1, 0, 2'b11, 1, 32'h400, 32'h0);
      run_access(0, 32'h81020304);
      checks++; if (obs_be !== 4'b1111) begin errors++; $display("[TB] FAIL sz11_be got %b want 1111", obs_be); end
      checks++; if (obs_rdata !== 32'h81020304) begin errors++; $display("[TB] FAIL sz11_rdata got %h want 81020304", obs_rdata); end
      checks++; if (obs_addr !== 30'h100) begin errors++; $display("[TB] FAIL sz11_addr got %h want 100", obs_addr); end
   endtask

   task automatic test_misaligned();
      set_access(1, 0, 2'b10, 0, 32'h101, 32'h0);
      #1;
      checks++; if ({AddrErr, Stall, mem_req} !== 3'b100) begin errors++; $display("[TB] FAIL mis_word got %b want 100", {AddrErr, Stall, mem_req}); end
      step();
      set_access(0, 1, 2'b01, 0, 32'h203, 32'hFFFF);
      #1;
      checks++; if ({AddrErr, Stall, mem_req} !== 3'b100) begin errors++; $display("[TB] FAIL mis_half got %b want 100", {AddrErr, Stall, mem_req}); end
      step();
      MemWrite = 1'b0;
      #1;
      checks++; if ({AddrErr, Stall, mem_req} !== 3'b000) begin errors++; $display("[TB] FAIL mis_after got %b want 000", {AddrErr, Stall, mem_req}); end
      checks++; if (ReadData !== 32'h81020304) begin errors++; $display("[TB] FAIL mis_rdata got %h want 81020304", ReadData); end
      step();
   endtask

   task automatic test_reset_abort();
      set_access(1, 0, 2'b10, 0, 32'h500, 32'h0);
      step();
      #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_req got %b want 1", mem_req); end
      RST = 1'b1;
      step();
      RST = 1'b0;
      MemRead = 1'b0;
      #1;
      checks++; if ({mem_req, Stall} !== 2'b00) begin errors++; $display("[TB] FAIL abort_req got %b want 00", {mem_req, Stall}); end
      mem_ack = 1'b1;
      mem_rdata = 32'h12345678;
      step();
      mem_ack = 1'b0;
      #1;
      checks++; if (ReadData !== 32'd0) begin errors++; $display("[TB] FAIL late_ack_rdata got %h want 0", ReadData); end
      checks++; if ({mem_req, Stall, BusErr} !== 3'b000) begin errors++; $display("[TB] FAIL late_ack_flags got %b want 000", {mem_req, Stall, BusErr}); end
      set_access(1, 0, 2'b10, 0, 32'h600, 32'h0);
      run_access(0, 32'hCAFEF00D);
      checks++; if (obs_stall !== 2) begin errors++; $display("[TB] FAIL post_abort_stall got %0d want 2", obs_stall); end
      checks++; if (obs_rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL post_abort_rdata got %h want cafef00d", obs_rdata); end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_timeout();
      test_byte_load();
      test_half();
      test_write_priority();
      test_misaligned();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
